// File: rtl/sequenciador_barramento_pkg.sv
// Shared definitions for the register-bus transfer sequencer:
// command opcodes and FSM state encoding.
package sequenciador_barramento_pkg;

    typedef enum logic [1:0] {
        OP_MOVE = 2'd0,
        OP_SWAP = 2'd1,
        OP_LOAD = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MOV  = 3'd1,
        SW1  = 3'd2,
        SW2  = 3'd3,
        SW3  = 3'd4,
        LD   = 3'd5
    } state_t;

endpackage

// File: rtl/sequenciador_barramento_fila_comandos.sv
// Synchronous command FIFO; pointers carry an extra MSB so full and empty
// are told apart without a separate counter.
module fila_comandos
    import sequenciador_barramento_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sequenciador_barramento.sv
// Transfer sequencer for the shared register bus: expands queued MOVE/SWAP/LOAD
// commands into registered per-cycle load strobes and single-driver enables.
module sequenciador_barramento
    import sequenciador_barramento_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int IDXW  = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [IDXW-1:0] cmd_a,
    input  logic [IDXW-1:0] cmd_b,
    output logic [NREG-1:0] c,
    output logic [NREG-1:0] h,
    output logic            ext_en,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CW = 2 + 2*IDXW;
    localparam logic [IDXW-1:0] TMP = IDXW'(NREG-1);

    function automatic logic [NREG-1:0] sel(input logic [IDXW-1:0] idx);
        return NREG'(1) << idx;
    endfunction

    function automatic logic legal(input op_t op, input logic [IDXW-1:0] a,
                                   input logic [IDXW-1:0] b);
        logic ok;
        case (op)
            OP_MOVE: ok = (int'(a) < NREG) && (int'(b) < NREG) && (a != b);
            OP_SWAP: ok = (int'(a) < NREG) && (int'(b) < NREG) && (a != b)
                          && (a != TMP) && (b != TMP);
            OP_LOAD: ok = (int'(b) < NREG);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic            full, empty, pop;
    logic [CW-1:0]   fifo_data;
    op_t             fifo_op;
    logic [IDXW-1:0] fifo_a, fifo_b;

    fila_comandos #(.DEPTH(DEPTH), .W(CW)) u_fila (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid & ~full),
        .pop     (pop),
        .wr_data ({cmd_op, cmd_a, cmd_b}),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty)
    );

    assign fifo_op = op_t'(fifo_data[CW-1 -: 2]);
    assign fifo_a  = fifo_data[2*IDXW-1 -: IDXW];
    assign fifo_b  = fifo_data[IDXW-1:0];

    state_t          state, state_nx;
    logic [IDXW-1:0] ra, rb, ra_nx, rb_nx;
    logic [NREG-1:0] c_nx, h_nx;
    logic            ext_nx, done_nx, err_nx;

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        state_nx = state;
        ra_nx    = ra;
        rb_nx    = rb;
        c_nx     = '0;
        h_nx     = '0;
        ext_nx   = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        pop      = 1'b0;
        case (state)
            SW1: begin
                state_nx = SW2;
                h_nx     = sel(rb);
                c_nx     = sel(ra);
            end
            SW2: begin
                state_nx = SW3;
                h_nx     = sel(TMP);
                c_nx     = sel(rb);
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Final-step states pop the next entry so consecutive commands have no gap.
        if (!empty && (state == IDLE || state == MOV || state == SW3 || state == LD)) begin
            pop   = 1'b1;
            ra_nx = fifo_a;
            rb_nx = fifo_b;
            if (!legal(fifo_op, fifo_a, fifo_b)) begin
                err_nx   = 1'b1;
                state_nx = IDLE;
            end else begin
                case (fifo_op)
                    OP_MOVE: begin
                        state_nx = MOV;
                        h_nx     = sel(fifo_a);
                        c_nx     = sel(fifo_b);
                        done_nx  = 1'b1;
                    end
                    OP_SWAP: begin
                        state_nx = SW1;
                        h_nx     = sel(fifo_a);
                        c_nx     = sel(TMP);
                    end
                    default: begin
                        state_nx = LD;
                        ext_nx   = 1'b1;
                        c_nx     = sel(fifo_b);
                        done_nx  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            c      <= '0;
            h      <= '0;
            ext_en <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            c      <= c_nx;
            h      <= h_nx;
            ext_en <= ext_nx;
            done   <= done_nx;
            err    <= err_nx;
        end
    end

    always_ff @(posedge clk) begin
        ra <= ra_nx;
        rb <= rb_nx;
    end

    assign cmd_ready = ~full;
    assign busy      = (state != IDLE) || !empty || err;

endmodule

// File: tb/tb_sequenciador_barramento.sv
// Bench for sequenciador_barramento: directed timing cases plus a random command
// stream scored against a register-level model of each transfer's effect.
module tb_sequenciador_barramento;

    localparam int NREG = 4, IDXW = 2, DEPTH = 4, TMP = NREG - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic [1:0]      cmd_op = '0;
    logic [IDXW-1:0] cmd_a = '0, cmd_b = '0;
    logic            cmd_ready, ext_en, busy, done, err;
    logic [NREG-1:0] c, h;

    always #5 clk = ~clk;

    sequenciador_barramento #(.NREG(NREG), .IDXW(IDXW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .c(c), .h(h),
        .ext_en(ext_en), .busy(busy), .done(done), .err(err)
    );

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]      op;
        logic [IDXW-1:0] a;
        logic [IDXW-1:0] b;
    } cmd_t;

    cmd_t       expq[$];
    logic [5:0] plant[NREG];
    logic [5:0] model[NREG];
    logic [5:0] ext_data = '0;
    int cyc = 0, n_done = 0, n_err = 0, first_step = -1, last_done = -1;
    bit saw_full = 0;

    function automatic bit is_legal(input cmd_t k);
        case (k.op)
            2'd0:    return (k.a < NREG) && (k.b < NREG) && (k.a != k.b);
            2'd1:    return (k.a < NREG) && (k.b < NREG) && (k.a != k.b)
                            && (k.a != TMP) && (k.b != TMP);
            2'd2:    return (k.b < NREG);
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset && cmd_valid && cmd_ready) expq.push_back({cmd_op, cmd_a, cmd_b});
    end

    // Plant: registers loaded from the bus by the DUT's strobes.
    always @(negedge clk) begin
        cmd_t       k;
        logic [5:0] bus, t;
        check("inv_drivers", ($countones(h) + ext_en) <= 1, 1);
        check("inv_loads", $countones(c) <= 1, 1);
        check("inv_overlap", (c & h) == 0, 1);
        bus = ext_en ? ext_data : 6'd0;
        for (int i = 0; i < NREG; i++) if (h[i]) bus = plant[i];
        for (int i = 0; i < NREG; i++) if (c[i]) plant[i] = bus;
        if (c != 0 && first_step < 0) first_step = cyc;
        if (done || err) begin
            if (expq.size() == 0) begin
                check("pulse_without_cmd", expq.size(), 1);
            end else begin
                k = expq.pop_front();
                check("legality", done, is_legal(k));
                check("done_err_excl", done & err, 0);
                if (err) begin
                    n_err++;
                    check("err_quiet", {c, h, ext_en}, 0);
                end else begin
                    n_done++;
                    last_done = cyc;
                    case (k.op)
                        2'd0: begin
                            check("mov_h", h, 1 << k.a);
                            check("mov_c", c, 1 << k.b);
                            model[k.b] = model[k.a];
                        end
                        2'd1: begin
                            check("swp_h", h, 1 << TMP);
                            check("swp_c", c, 1 << k.b);
                            t = model[k.a];
                            model[k.a] = model[k.b];
                            model[k.b] = t;
                            model[TMP] = t;
                        end
                        default: begin
                            check("ld_ext", ext_en, 1);
                            check("ld_h", h, 0);
                            check("ld_c", c, 1 << k.b);
                            model[k.b] = ext_data;
                        end
                    endcase
                    for (int i = 0; i < NREG; i++) check("reg_file", plant[i], model[i]);
                end
            end
        end
        ext_data = 6'($urandom);
    end

    task automatic send(input int op, input int a, input int b);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_op = 2'(op);
        cmd_a = IDXW'(a);
        cmd_b = IDXW'(b);
        while (!cmd_ready && t < 200) begin
            saw_full = 1;
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", t, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", t < 500, 1);
    endtask

    task automatic sync_model();
        for (int i = 0; i < NREG; i++) model[i] = plant[i];
    endtask

    initial begin
        int d0, e0, r;
        for (int i = 0; i < NREG; i++) plant[i] = 6'($urandom);
        sync_model();

        repeat (2) @(negedge clk);
        check("rst_outs", {c, h, ext_en, done, err, busy}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);

        // MOVE 0->1: first-step latency and busy release.
        cmd_valid = 1; cmd_op = 2'd0; cmd_a = 0; cmd_b = 1;
        @(negedge clk);
        cmd_valid = 0;
        check("mv_wait_h", h, 0);
        check("mv_wait_busy", busy, 1);
        @(negedge clk);
        check("mv_h1", h, 4'b0001);
        check("mv_c1", c, 4'b0010);
        check("mv_done1", done, 1);
        @(negedge clk);
        check("mv_busy_end", busy, 0);
        check("mv_done_end", done, 0);

        // SWAP 0<->1 with preloaded values.
        plant[0] = 6'd5; plant[1] = 6'd9;
        sync_model();
        send(1, 0, 1);
        @(negedge clk);
        check("sw_s1", {h, c, done}, {4'b0001, 4'b1000, 1'b0});
        @(negedge clk);
        check("sw_s2", {h, c, done}, {4'b0010, 4'b0001, 1'b0});
        @(negedge clk);
        check("sw_s3", {h, c, done}, {4'b1000, 4'b0010, 1'b1});
        wait_idle();
        check("sw_r0", plant[0], 9);
        check("sw_r1", plant[1], 5);

        // Burst: fills the FIFO and must run with no gap cycles.
        d0 = n_done; first_step = -1; saw_full = 0;
        send(1, 0, 1); send(1, 1, 2); send(0, 0, 3); send(1, 2, 0);
        send(2, 0, 3); send(1, 0, 1); send(0, 1, 2); send(1, 1, 0);
        wait_idle();
        check("burst_full_seen", saw_full, 1);
        check("burst_dones", n_done - d0, 8);
        check("burst_span", last_done - first_step + 1, 18);

        // Illegal commands followed by a legal LOAD.
        d0 = n_done; e0 = n_err;
        send(0, 2, 2); send(1, 0, 3); send(3, 1, 2); send(2, 0, 2);
        wait_idle();
        check("ill_errs", n_err - e0, 3);
        check("ill_dones", n_done - d0, 1);

        // Reset during SW2 with two commands queued.
        send(1, 0, 1); send(0, 2, 0); send(0, 1, 2);
        #1 reset = 1'b1;
        expq.delete();
        #1;
        check("mid_rst_outs", {c, h, ext_en, done, err, busy}, 0);
        sync_model();
        d0 = n_done;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_nodone", n_done - d0, 0);
        check("mid_rst_idle", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        send(2, 0, 1);
        wait_idle();
        check("post_rst_load", n_done - d0, 1);

        // Random legal/illegal stream.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            send(r < 3 ? 0 : r < 6 ? 1 : r < 9 ? 2 : 3,
                 $urandom_range(0, NREG-1), $urandom_range(0, NREG-1));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_idle();
        check("rand_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
